// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder: measures burst/space widths in microsecond ticks,
// validates leader, 32 data bits and complement bytes, and flags repeat frames.
module nec_ir_decoder #(
  parameter int CLK_FREQ   = 1_000_000,
  parameter int CHECK_ADDR = 1,
  parameter int TIMEOUT_US = 12000
) (
  input  logic       clk_hz,
  input  logic       rst_n,
  input  logic       ir_in,
  output logic [7:0] ir_code,
  output logic [7:0] ir_addr,
  output logic       ir_valid,
  output logic       ir_repeat,
  output logic       ir_err,
  output logic       ir_busy
);

  // state     | meaning
  // IDLE      | waiting for leader burst
  // LEAD_LOW  | timing 9 ms leader burst
  // LEAD_HIGH | timing leader space (data or repeat)
  // BIT_LOW   | timing bit burst
  // BIT_HIGH  | timing bit space, shifting in data
  // STOP_LOW  | timing final stop burst
  // CHECK     | verifying complement bytes
  // REP_STOP  | timing repeat-frame stop burst
  // ERR       | one-cycle error strobe
  typedef enum logic [3:0] {
    IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, STOP_LOW, CHECK, REP_STOP, ERR
  } state_t;

  localparam int PRE_MAX = CLK_FREQ / 1_000_000 - 1;
  localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
  localparam logic [13:0] TIMEOUT = 14'(TIMEOUT_US);

  function automatic logic in_win(input logic [13:0] w, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  state_t           state, state_nx;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic             s1, s2, s3;
  logic             fall, rise;
  logic [13:0]      width;
  logic [31:0]      shift, shift_nx;
  logic [4:0]       bit_cnt, bit_cnt_nx;
  logic             have_code;
  logic             valid_nx, repeat_nx, err_nx, load;
  logic             lead_l, lead_h_data, lead_h_rep, bit_l, bit1_h;
  logic             cmd_ok, addr_ok, waiting, timeout;

  assign tick = (pre == PRE_W'(PRE_MAX));
  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;

  always_ff @(posedge clk_hz or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      s1    <= 1'b1;
      s2    <= 1'b1;
      s3    <= 1'b1;
      width <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      s1  <= ir_in;
      s2  <= s1;
      s3  <= s2;
      // width is sampled by the FSM this cycle, then restarts for the new phase
      if (fall || rise)                width <= {13'd0, tick};
      else if (tick && width != 14'h3FFF) width <= width + 14'd1;
    end
  end

  assign lead_l      = in_win(width, 14'd8000, 14'd10000);
  assign lead_h_data = in_win(width, 14'd4000, 14'd5000);
  assign lead_h_rep  = in_win(width, 14'd2000, 14'd2500);
  assign bit_l       = in_win(width, 14'd400,  14'd700);
  assign bit1_h      = in_win(width, 14'd1400, 14'd1900);
  assign cmd_ok      = (shift[23:16] == ~shift[31:24]);
  assign addr_ok     = (CHECK_ADDR == 0) || (shift[7:0] == ~shift[15:8]);
  assign waiting     = (state != IDLE) && (state != CHECK) && (state != ERR);
  assign timeout     = (width > TIMEOUT);
  assign ir_busy     = (state != IDLE);

  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    bit_cnt_nx = bit_cnt;
    valid_nx   = 1'b0;
    repeat_nx  = 1'b0;
    err_nx     = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE:      if (fall) state_nx = LEAD_LOW;
      LEAD_LOW:  if (rise) state_nx = lead_l ? LEAD_HIGH : ERR;
      LEAD_HIGH: if (fall) begin
        if (lead_h_data) begin
          state_nx   = BIT_LOW;
          bit_cnt_nx = '0;
        end else if (lead_h_rep) state_nx = REP_STOP;
        else                     state_nx = ERR;
      end
      BIT_LOW:   if (rise) state_nx = bit_l ? BIT_HIGH : ERR;
      BIT_HIGH:  if (fall) begin
        if (bit_l || bit1_h) begin
          shift_nx = {bit1_h, shift[31:1]};
          if (bit_cnt == 5'd31) state_nx = STOP_LOW;
          else begin
            bit_cnt_nx = bit_cnt + 5'd1;
            state_nx   = BIT_LOW;
          end
        end else state_nx = ERR;
      end
      STOP_LOW:  if (rise) state_nx = bit_l ? CHECK : ERR;
      CHECK: begin
        if (cmd_ok && addr_ok) begin
          valid_nx = 1'b1;
          load     = 1'b1;
          state_nx = IDLE;
        end else state_nx = ERR;
      end
      REP_STOP:  if (rise) begin
        if (bit_l && have_code) begin
          repeat_nx = 1'b1;
          state_nx  = IDLE;
        end else state_nx = ERR;
      end
      ERR: begin
        err_nx   = 1'b1;
        state_nx = IDLE;
      end
      default:   state_nx = IDLE;
    endcase
    if (waiting && timeout) begin
      state_nx  = ERR;
      repeat_nx = 1'b0;
    end
  end

  always_ff @(posedge clk_hz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      have_code <= 1'b0;
      ir_code   <= 8'h00;
      ir_addr   <= 8'h00;
      ir_valid  <= 1'b0;
      ir_repeat <= 1'b0;
      ir_err    <= 1'b0;
    end else begin
      state     <= state_nx;
      shift     <= shift_nx;
      bit_cnt   <= bit_cnt_nx;
      ir_valid  <= valid_nx;
      ir_repeat <= repeat_nx;
      ir_err    <= err_nx;
      if (load) begin
        ir_code   <= shift[23:16];
        ir_addr   <= shift[7:0];
        have_code <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed bench for nec_ir_decoder: table of frames plus hand-written
// sequences for latency, timeout, bad leader and mid-frame reset.
`timescale 1ns/1ps
module tb_nec_ir_decoder;

  logic       clk_hz = 1'b0;
  logic       rst_n;
  logic       ir_in;
  logic [7:0] code0, addr0, code1, addr1;
  logic       valid0, rep0, err0, busy0;
  logic       valid1, rep1, err1, busy1;

  nec_ir_decoder #(.CLK_FREQ(1_000_000), .CHECK_ADDR(1), .TIMEOUT_US(12000)) dut0 (
    .clk_hz(clk_hz), .rst_n(rst_n), .ir_in(ir_in), .ir_code(code0), .ir_addr(addr0),
    .ir_valid(valid0), .ir_repeat(rep0), .ir_err(err0), .ir_busy(busy0));

  nec_ir_decoder #(.CLK_FREQ(1_000_000), .CHECK_ADDR(0), .TIMEOUT_US(12000)) dut1 (
    .clk_hz(clk_hz), .rst_n(rst_n), .ir_in(ir_in), .ir_code(code1), .ir_addr(addr1),
    .ir_valid(valid1), .ir_repeat(rep1), .ir_err(err1), .ir_busy(busy1));

  always #500 clk_hz = ~clk_hz;

  int n_cmp = 0;
  int n_bad = 0;
  int n_v0 = 0, n_r0 = 0, n_e0 = 0, n_v1 = 0, n_e1 = 0, n_ovl = 0;
  int s_v0, s_r0, s_e0, s_v1, s_e1;

  always @(negedge clk_hz) begin
    if (rst_n) begin
      if (valid0) n_v0++;
      if (rep0)   n_r0++;
      if (err0)   n_e0++;
      if (valid1) n_v1++;
      if (err1)   n_e1++;
      if ((valid0 && rep0) || (valid0 && err0) || (rep0 && err0) ||
          (valid1 && rep1) || (valid1 && err1) || (rep1 && err1)) n_ovl++;
    end
  end

  typedef struct {
    bit         rep;
    logic [7:0] a, na, c, nc;
    int         ev, er, ee;
    logic [7:0] ecode, eaddr;
    int         ev1, ee1;
    logic [7:0] ecode1;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_v0 = n_v0; s_r0 = n_r0; s_e0 = n_e0; s_v1 = n_v1; s_e1 = n_e1;
  endtask

  task automatic phase(input logic lvl, input int n);
    ir_in = lvl;
    repeat (n) @(posedge clk_hz);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] data, input int nbits);
    phase(1'b0, 8200);
    phase(1'b1, 4100);
    for (int i = 0; i < nbits; i++) begin
      phase(1'b0, 450);
      phase(1'b1, data[i] ? 1450 : 450);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] na,
                            input logic [7:0] c, input logic [7:0] nc);
    send_bits({nc, c, na, a}, 32);
    phase(1'b0, 450);
    ir_in = 1'b1;
  endtask

  task automatic send_repeat();
    phase(1'b0, 8200);
    phase(1'b1, 2100);
    phase(1'b0, 450);
    ir_in = 1'b1;
  endtask

  task automatic settle();
    repeat (30) @(posedge clk_hz);
    #1;
  endtask

  initial begin
    int lat;
    vecs[0] = '{rep:1'b0, a:8'h00, na:8'hFF, c:8'h0C, nc:8'hF3, ev:1, er:0, ee:0,
                ecode:8'h0C, eaddr:8'h00, ev1:1, ee1:0, ecode1:8'h0C};
    vecs[1] = '{rep:1'b1, a:8'h00, na:8'h00, c:8'h00, nc:8'h00, ev:0, er:1, ee:0,
                ecode:8'h0C, eaddr:8'h00, ev1:0, ee1:0, ecode1:8'h0C};
    vecs[2] = '{rep:1'b0, a:8'h00, na:8'hFF, c:8'h18, nc:8'h18, ev:0, er:0, ee:1,
                ecode:8'h0C, eaddr:8'h00, ev1:0, ee1:1, ecode1:8'h0C};
    vecs[3] = '{rep:1'b0, a:8'h01, na:8'h01, c:8'h22, nc:8'hDD, ev:0, er:0, ee:1,
                ecode:8'h0C, eaddr:8'h00, ev1:1, ee1:0, ecode1:8'h22};

    ir_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_hz);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_hz);
    #1;
    check("reset code",   32'(code0),  32'h00);
    check("reset addr",   32'(addr0),  32'h00);
    check("reset valid",  32'(valid0), 32'h0);
    check("reset repeat", 32'(rep0),   32'h0);
    check("reset err",    32'(err0),   32'h0);
    check("reset busy",   32'(busy0),  32'h0);

    // repeat frame with no stored code
    snap();
    send_repeat();
    settle();
    check("rep-after-reset err",    n_e0 - s_e0, 1);
    check("rep-after-reset repeat", n_r0 - s_r0, 0);
    check("rep-after-reset code",   32'(code0), 32'h00);

    // first full frame with latency measurement from the stop rise
    snap();
    send_frame(8'h00, 8'hFF, 8'h16, 8'hE9);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk_hz);
      #1;
      if (valid0 && lat == 0) lat = i;
    end
    settle();
    check("frame16 latency", lat, 4);
    check("frame16 valid",   n_v0 - s_v0, 1);
    check("frame16 err",     n_e0 - s_e0, 0);
    check("frame16 code",    32'(code0), 32'h16);
    check("frame16 addr",    32'(addr0), 32'h00);

    for (int k = 0; k < 4; k++) begin
      snap();
      if (vecs[k].rep) send_repeat();
      else send_frame(vecs[k].a, vecs[k].na, vecs[k].c, vecs[k].nc);
      settle();
      check($sformatf("vec%0d valid", k),  n_v0 - s_v0, vecs[k].ev);
      check($sformatf("vec%0d repeat", k), n_r0 - s_r0, vecs[k].er);
      check($sformatf("vec%0d err", k),    n_e0 - s_e0, vecs[k].ee);
      check($sformatf("vec%0d code", k),   32'(code0), 32'(vecs[k].ecode));
      check($sformatf("vec%0d addr", k),   32'(addr0), 32'(vecs[k].eaddr));
      check($sformatf("vec%0d valid1", k), n_v1 - s_v1, vecs[k].ev1);
      check($sformatf("vec%0d err1", k),   n_e1 - s_e1, vecs[k].ee1);
      check($sformatf("vec%0d code1", k),  32'(code1), 32'(vecs[k].ecode1));
    end

    // short leader burst
    snap();
    phase(1'b0, 7000);
    ir_in = 1'b1;
    settle();
    check("short-leader err",  n_e0 - s_e0, 1);
    check("short-leader busy", 32'(busy0), 32'h0);
    check("short-leader code", 32'(code0), 32'h0C);

    // stuck-low line after a valid leader
    snap();
    phase(1'b0, 8200);
    phase(1'b1, 4100);
    phase(1'b0, 11900);
    check("timeout early err", n_e0 - s_e0, 0);
    check("timeout busy",      32'(busy0), 32'h1);
    phase(1'b0, 1100);
    check("timeout err",       n_e0 - s_e0, 1);
    check("timeout valid",     n_v0 - s_v0, 0);
    phase(1'b1, 100);
    snap();
    send_frame(8'h00, 8'hFF, 8'h33, 8'hCC);
    settle();
    check("post-timeout valid", n_v0 - s_v0, 1);
    check("post-timeout err",   n_e0 - s_e0, 0);
    check("post-timeout code",  32'(code0), 32'h33);

    // reset while inside bit 17
    snap();
    send_bits({8'hA1, 8'h5E, 8'hFF, 8'h00}, 17);
    ir_in = 1'b0;
    repeat (200) @(posedge clk_hz);
    #1;
    check("pre-reset busy", 32'(busy0), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid-reset code",   32'(code0),  32'h00);
    check("mid-reset addr",   32'(addr0),  32'h00);
    check("mid-reset busy",   32'(busy0),  32'h0);
    check("mid-reset strobe", 32'({valid0, rep0, err0}), 32'h0);
    ir_in = 1'b1;
    repeat (5) @(posedge clk_hz);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk_hz);
    #1;
    check("post-reset strobes", (n_v0 - s_v0) + (n_r0 - s_r0) + (n_e0 - s_e0), 0);
    snap();
    send_frame(8'h00, 8'hFF, 8'h5E, 8'hA1);
    settle();
    check("frame5E valid", n_v0 - s_v0, 1);
    check("frame5E err",   n_e0 - s_e0, 0);
    check("frame5E code",  32'(code0), 32'h5E);

    check("strobe exclusivity", n_ovl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nec_ir_decoder.md
Name: nec_ir_decoder

Overview:
- Decodes the demodulated NEC infrared receiver output (idle-high, burst = low) into 8-bit key codes.
- Produces the `ir_code` byte and strobes consumed by the remote-entry and frequency-setting logic.
- Validates leader, 32 data bits and complement bytes, and also detects NEC repeat frames.
- Runs on the slow sampling clock `clk_hz`; all pulse widths are measured in microsecond ticks.

Parameters:
- CLK_FREQ, 1_000_000, frequency of `clk_hz` in Hz; must be an integer multiple of 1 MHz.
- CHECK_ADDR, 1, 1 = reject frames whose address byte != ~address-complement byte; 0 = check command complement only.
- TIMEOUT_US, 12000, any single low or high phase longer than this aborts the frame.

Ports:
- clk_hz  input  1  sampling clock.
- rst_n  input  1  reset; asynchronous, active-low; clock clk_hz.
- ir_in  input  1  raw IR receiver output, asynchronous, idle high.
- ir_code  output  8  last valid command byte.
- ir_addr  output  8  last valid address byte.
- ir_valid  output  1  one-cycle pulse when a new full frame is accepted.
- ir_repeat  output  1  one-cycle pulse on a valid repeat frame.
- ir_err  output  1  one-cycle pulse on any aborted or malformed frame.
- ir_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: `ir_code` = 8'h00, `ir_addr` = 8'h00, `ir_valid`/`ir_repeat`/`ir_err` = 0, `ir_busy` = 0, FSM = IDLE, `have_code` = 0. Synchroniser flops reset to 1.
- Input conditioning: 2-flop synchroniser, then a registered copy for edge detection. A fall or rise is detected 3 `clk_hz` cycles after the pin edge.
- Time base: prescaler counts 0..CLK_FREQ/1e6-1 and emits a 1 µs tick. Phase counter `width` is 14 bits, increments on each tick, saturates at 16383, and clears on every detected edge after its value is sampled.
- Phase classification is done on the `width` value captured at the edge that ends the phase:
  - LEAD_L: 8000..10000
  - LEAD_H_DATA: 4000..5000
  - LEAD_H_REP: 2000..2500
  - BIT_L: 400..700
  - BIT0_H: 400..700
  - BIT1_H: 1400..1900
  - All bounds inclusive.
- FSM states and transitions:
  - IDLE: on fall → LEAD_LOW.
  - LEAD_LOW: on rise, if LEAD_L → LEAD_HIGH, else ERR.
  - LEAD_HIGH: on fall:
    - LEAD_H_DATA → BIT_LOW, with bit counter = 0.
    - LEAD_H_REP → REP_STOP.
    - else ERR.
  - BIT_LOW: on rise, if BIT_L → BIT_HIGH, else ERR.
  - BIT_HIGH: on fall:
    - BIT0_H shifts in 0, BIT1_H shifts in 1, else ERR.
    - Bits are shifted LSB-first into a 32-bit shift register.
    - If bit counter = 31 after the shift → STOP_LOW; else bit counter +1 → BIT_LOW.
  - STOP_LOW: on rise, if BIT_L → CHECK, else ERR.
  - CHECK (1 cycle):
    - byte0 = addr, byte1 = ~addr, byte2 = cmd, byte3 = ~cmd.
    - If complements pass: `ir_code` <= cmd, `ir_addr` <= addr, `ir_valid` = 1, `have_code` = 1 → IDLE.
    - Else → ERR.
  - REP_STOP: on rise, if BIT_L:
    - If `have_code` = 1: `ir_repeat` = 1, outputs unchanged → IDLE.
    - Otherwise → ERR.
    - A non-BIT_L width → ERR.
  - ERR (1 cycle): `ir_err` = 1 → IDLE. `ir_code`/`ir_addr` retain their previous values.
- Timeout: in any non-IDLE state, `width` > TIMEOUT_US → ERR without waiting for an edge.
- In IDLE, `width` runs freely (saturating); no timeout is applied.
- Glitches: an edge arriving in a state that expects the opposite polarity cannot occur after synchronisation. Any out-of-window width → ERR.
- Latency: `ir_valid` asserts 1 cycle after the stop-burst rise is detected, i.e. 4 `clk_hz` cycles after the pin edge.
- Reset mid-frame: all state returns to reset values immediately and no strobe is emitted. The first subsequent fall starts a fresh frame.
- `ir_valid`, `ir_repeat` and `ir_err` are mutually exclusive and never asserted together.

Test Plan:
- CLK_FREQ = 1e6: frame with addr 8'h00 and cmd 8'h16 (9000/4500, standard bits, stop) → single `ir_valid` pulse 4 cycles after the stop rise; `ir_code` = 8'h16, `ir_addr` = 8'h00, `ir_err` never high.
- Valid frame cmd 8'h0C, then repeat frame 9000 L / 2250 H / 560 L → one `ir_valid`, then one `ir_repeat`; `ir_code` stays 8'h0C.
- Repeat frame immediately after reset → `ir_err` pulse, no `ir_repeat`, `ir_code` = 8'h00.
- Frame cmd 8'h18 with byte3 = 8'h18 (bad complement) → `ir_err`; `ir_code` keeps the prior value. Repeat with addr 8'h01 / ~addr 8'h01 for CHECK_ADDR = 1 → `ir_err`; for CHECK_ADDR = 0 → `ir_valid`.
- Leader low 7000 µs → `ir_err` at the rise. Ir_in held low 13000 µs after a valid leader → `ir_err` when `width` passes 12000, then a fresh valid frame decodes normally.
- Assert `rst_n` low during bit 17 of a frame → all outputs 0 and `ir_busy` 0 immediately; no strobe; the following complete frame (cmd 8'h5E) gives `ir_valid` with `ir_code` = 8'h5E.
